// File: rtl/mac_vector_acc.sv
// rtl/mac_vector_acc.sv - multi-lane signed MAC with bias preload, streaming input and requantised held result
// Optional feature macro: MAC_VECTOR_ACC_SAT_EN (saturating narrow and sat_out flags)
module mac_vector_acc #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int VECTOR_WIDTH = 4,
    parameter int ACC_WIDTH    = 24,
    parameter int OUTPUT_WIDTH = 16,
    parameter int OUT_SHIFT    = 0,
    parameter int LEN_WIDTH    = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [LEN_WIDTH-1:0]                       len,
    input  logic [VECTOR_WIDTH-1:0][OUTPUT_WIDTH-1:0]  bias_in,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [VECTOR_WIDTH-1:0][DATA_WIDTH-1:0]    val_in,
    input  logic [VECTOR_WIDTH-1:0][WEIGHT_WIDTH-1:0]  weight_in,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [VECTOR_WIDTH-1:0][OUTPUT_WIDTH-1:0]  sum_out,
    output logic [VECTOR_WIDTH-1:0]                    sat_out,
    output logic                                       busy
);

    localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCUM  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

`ifdef MAC_VECTOR_ACC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((2 ** (OUTPUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - ACC_WIDTH'(1);
`endif

    logic [1:0]                         state;
    logic [LEN_WIDTH-1:0]               len_q;
    logic [LEN_WIDTH-1:0]               cnt;
    logic                               prod_vld;
    logic signed [PW-1:0]               prod    [VECTOR_WIDTH];
    logic signed [ACC_WIDTH-1:0]        acc     [VECTOR_WIDTH];
    logic signed [ACC_WIDTH-1:0]        shifted [VECTOR_WIDTH];
    logic [VECTOR_WIDTH-1:0][OUTPUT_WIDTH-1:0] narrow_val;
    logic [VECTOR_WIDTH-1:0]            narrow_sat;
    logic                               accept;

    assign in_ready = (state == S_ACCUM);
    assign busy     = (state != S_IDLE);
    assign accept   = in_valid && in_ready;

    // Requantisation: arithmetic shift then either clamp or keep the low bits.
    always_comb begin
        narrow_val = '0;
        narrow_sat = '0;
        for (int i = 0; i < VECTOR_WIDTH; i++) begin
            shifted[i] = acc[i] >>> OUT_SHIFT;
`ifdef MAC_VECTOR_ACC_SAT_EN
            if (shifted[i] > SAT_MAX) begin
                narrow_val[i] = OUTPUT_WIDTH'(SAT_MAX);
                narrow_sat[i] = 1'b1;
            end else if (shifted[i] < SAT_MIN) begin
                narrow_val[i] = OUTPUT_WIDTH'(SAT_MIN);
                narrow_sat[i] = 1'b1;
            end else begin
                narrow_val[i] = OUTPUT_WIDTH'(shifted[i]);
            end
`else
            narrow_val[i] = OUTPUT_WIDTH'(shifted[i]);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            len_q     <= '0;
            cnt       <= '0;
            prod_vld  <= 1'b0;
            out_valid <= 1'b0;
            sum_out   <= '0;
            sat_out   <= '0;
            for (int i = 0; i < VECTOR_WIDTH; i++) begin
                prod[i] <= '0;
                acc[i]  <= '0;
            end
        end else begin
            prod_vld <= accept;
            if (accept) begin
                cnt <= cnt + LEN_WIDTH'(1);
                for (int i = 0; i < VECTOR_WIDTH; i++) begin
                    prod[i] <= $signed(val_in[i]) * $signed(weight_in[i]);
                end
            end
            if (prod_vld) begin
                for (int i = 0; i < VECTOR_WIDTH; i++) begin
                    acc[i] <= acc[i] + ACC_WIDTH'(prod[i]);
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q <= len;
                        cnt   <= '0;
                        for (int i = 0; i < VECTOR_WIDTH; i++) begin
                            acc[i] <= ACC_WIDTH'($signed(bias_in[i]));
                        end
                        state <= (len == '0) ? S_DRAIN : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept && (cnt == len_q - LEN_WIDTH'(1))) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state <= S_OUTPUT;
                end
                default: begin
                    // First OUTPUT cycle captures the settled accumulators; then hold until taken.
                    if (!out_valid) begin
                        sum_out   <= narrow_val;
                        sat_out   <= narrow_sat;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_vector_acc.sv
// tb/tb_mac_vector_acc.sv - randomized self-checking bench for mac_vector_acc against a dot-product model
module tb_mac_vector_acc;

    localparam int VW = 4;
    localparam int OUT_SHIFT = 0;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [7:0]           len;
    logic [VW-1:0][15:0]  bias_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [VW-1:0][7:0]   val_in;
    logic [VW-1:0][7:0]   weight_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [VW-1:0][15:0]  sum_out;
    logic [VW-1:0]        sat_out;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int                 job_len;
    logic signed [15:0] job_bias [VW];
    logic signed [7:0]  job_val  [256][VW];
    logic signed [7:0]  job_wt   [256][VW];
    logic signed [15:0] last_sum [VW];

    mac_vector_acc dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bias_in(bias_in),
        .in_valid(in_valid), .in_ready(in_ready), .val_in(val_in), .weight_in(weight_in),
        .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out),
        .sat_out(sat_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: bias plus plain integer dot product, shifted, then narrowed.
    function automatic logic signed [15:0] model_lane(input int lane, output logic sat);
        longint s;
        logic [15:0] lo;
        s = longint'(job_bias[lane]);
        for (int b = 0; b < job_len; b++) s += longint'(job_val[b][lane]) * longint'(job_wt[b][lane]);
        s = s >>> OUT_SHIFT;
        sat = 1'b0;
`ifdef MAC_VECTOR_ACC_SAT_EN
        if (s > 32767) begin sat = 1'b1; return 16'sd32767; end
        if (s < -32768) begin sat = 1'b1; return -16'sd32768; end
`endif
        lo = s[15:0];
        return $signed(lo);
    endfunction

    task automatic run_job(input int max_gap, input int hold, input string name);
        int acc_cyc, lat, c, waited;
        logic rdy, seen_ready, stable_ok, sat_e;
        logic signed [15:0] exp_v;
        logic [VW-1:0][15:0] held;
        start = 1'b1;
        len = 8'(job_len);
        for (int l = 0; l < VW; l++) bias_in[l] = job_bias[l];
        acc_cyc = cyc;
        tick();
        start = 1'b0;
        for (int b = 0; b < job_len; b++) begin
            int gap;
            gap = (max_gap < 0) ? ((b == 1) ? 2 : (b == 2) ? 5 : 0) : int'($urandom_range(max_gap, 0));
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                start = 1'($urandom_range(1, 0));
                val_in = VW*8'($urandom);
                tick();
            end
            start = 1'b0;
            in_valid = 1'b1;
            for (int l = 0; l < VW; l++) begin
                val_in[l] = job_val[b][l];
                weight_in[l] = job_wt[b][l];
            end
            waited = 0;
            do begin
                rdy = in_ready;
                c = cyc;
                tick();
                waited++;
            end while (!rdy && waited < 50);
            checks++;
            if (!rdy) begin
                errors++;
                $display("FAIL %s beat%0d in_ready: got 0 want 1", name, b);
            end
            acc_cyc = c;
        end
        in_valid = 1'b0;
        seen_ready = 1'b0;
        for (int w = 0; w < 20 && !out_valid; w++) begin
            if (in_ready) seen_ready = 1'b1;
            tick();
        end
        lat = cyc - acc_cyc;
        checks++;
        if (lat !== 3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s latency: got %0d valid=%b want 3 valid=1", name, lat, out_valid);
        end
        checks++;
        if (seen_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s drain_in_ready: got 1 want 0", name);
        end
        for (int l = 0; l < VW; l++) begin
            exp_v = model_lane(l, sat_e);
            last_sum[l] = $signed(sum_out[l]);
            checks++;
            if ($signed(sum_out[l]) !== exp_v || sat_out[l] !== sat_e) begin
                errors++;
                $display("FAIL %s lane%0d sum/sat: got %0d/%b want %0d/%b", name, l,
                         $signed(sum_out[l]), sat_out[l], exp_v, sat_e);
            end
        end
        held = sum_out;
        stable_ok = 1'b1;
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = 1'($urandom_range(1, 0));
            tick();
            if (sum_out !== held || out_valid !== 1'b1 || busy !== 1'b1) stable_ok = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (!stable_ok) begin
            errors++;
            $display("FAIL %s hold_stable: got sum=%h valid=%b want sum=%h valid=1", name, sum_out, out_valid, held);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: got valid=%b busy=%b want 0/0", name, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        logic ok;
        rst = 1'b1;
        start = 1'b0; len = '0; bias_in = '0; in_valid = 1'b0; out_ready = 1'b0;
        val_in = '0; weight_in = '0;
        tick(); tick();
        rst = 1'b0;
        in_valid = 1'b1;
        val_in = VW*8'($urandom);
        weight_in = VW*8'($urandom);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || sum_out !== '0 || sat_out !== '0) ok = 1'b0;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_idle: got rdy=%b ov=%b busy=%b sum=%h want all 0", in_ready, out_valid, busy, sum_out);
        end
    endtask

    task automatic test_basic();
        int v0 [3] = '{2, 4, -1};
        int w0 [3] = '{3, -1, -1};
        job_len = 3;
        job_bias[0] = 16'sd10; job_bias[1] = 16'sd0; job_bias[2] = -16'sd5; job_bias[3] = 16'sd0;
        for (int b = 0; b < 3; b++) begin
            job_val[b][0] = 8'(v0[b]);
            job_wt[b][0] = 8'(w0[b]);
            for (int l = 1; l < VW; l++) begin
                job_val[b][l] = 8'($urandom);
                job_wt[b][l] = 8'($urandom);
            end
        end
        run_job(0, 1, "basic");
        checks++;
        if (last_sum[0] !== 16'sd13) begin
            errors++;
            $display("FAIL basic_lane0_const: got %0d want 13", last_sum[0]);
        end
    endtask

    task automatic test_stall_backpressure();
        logic signed [15:0] ref_sum [VW];
        job_len = 4;
        for (int l = 0; l < VW; l++) job_bias[l] = 16'($urandom_range(2000, 0)) - 16'sd1000;
        for (int b = 0; b < 4; b++)
            for (int l = 0; l < VW; l++) begin
                job_val[b][l] = 8'($urandom);
                job_wt[b][l] = 8'($urandom);
            end
        run_job(0, 0, "gapfree");
        for (int l = 0; l < VW; l++) ref_sum[l] = last_sum[l];
        run_job(-1, 7, "stall");
        checks++;
        if (last_sum[0] !== ref_sum[0] || last_sum[1] !== ref_sum[1] ||
            last_sum[2] !== ref_sum[2] || last_sum[3] !== ref_sum[3]) begin
            errors++;
            $display("FAIL stall_vs_gapfree: got %0d want %0d (lane0)", last_sum[0], ref_sum[0]);
        end
    endtask

    task automatic test_len_zero();
        job_len = 0;
        job_bias[0] = -16'sd32768; job_bias[1] = 16'sd1; job_bias[2] = 16'sd2; job_bias[3] = 16'sd3;
        run_job(0, 2, "len0");
    endtask

    task automatic test_saturation();
        job_len = 8;
        for (int l = 0; l < VW; l++) job_bias[l] = 16'sd0;
        for (int b = 0; b < 8; b++)
            for (int l = 0; l < VW; l++) begin
                job_val[b][l] = 8'sd127;
                job_wt[b][l] = 8'sd127;
            end
        run_job(1, 1, "sat");
        checks++;
`ifdef MAC_VECTOR_ACC_SAT_EN
        if (last_sum[0] !== 16'sd32767 || sat_out !== 4'hF) begin
            errors++;
            $display("FAIL sat_const: got %0d sat=%h want 32767 sat=f", last_sum[0], sat_out);
        end
`else
        if (last_sum[0] !== -16'sd2040 || sat_out !== 4'h0) begin
            errors++;
            $display("FAIL wrap_const: got %0d sat=%h want -2040 sat=0", last_sum[0], sat_out);
        end
`endif
    endtask

    task automatic test_mid_reset();
        int accepted = 0;
        start = 1'b1;
        len = 8'd5;
        bias_in = VW*16'($urandom);
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        val_in = VW*8'($urandom);
        weight_in = VW*8'($urandom);
        for (int i = 0; i < 10 && accepted < 2; i++) begin
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || sum_out !== '0) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b rdy=%b ov=%b sum=%h want 0", busy, in_ready, out_valid, sum_out);
        end
        tick();
        rst = 1'b0;
        tick();
        job_len = 1;
        for (int l = 0; l < VW; l++) begin
            job_bias[l] = 16'sd0;
            job_val[0][l] = 8'sd3;
            job_wt[0][l] = 8'sd3;
        end
        run_job(0, 0, "after_reset");
        checks++;
        if (last_sum[0] !== 16'sd9) begin
            errors++;
            $display("FAIL after_reset_const: got %0d want 9", last_sum[0]);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            job_len = int'($urandom_range(12, 1));
            for (int l = 0; l < VW; l++) job_bias[l] = 16'($urandom);
            for (int b = 0; b < job_len; b++)
                for (int l = 0; l < VW; l++) begin
                    job_val[b][l] = 8'($urandom);
                    job_wt[b][l] = 8'($urandom);
                end
            run_job(3, int'($urandom_range(4, 0)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_backpressure();
        test_len_zero();
        test_saturation();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/mac_vector_acc.md
Name: mac_vector_acc

Overview:
- Parametrised successor to the lane-vector FMA: VECTOR_WIDTH independent signed multiply-accumulate lanes with a programmable dot-product length.
- Bias preload, ready/valid input streaming, and a held ready/valid result.
- Right-shift requantisation of each result to OUTPUT_WIDTH.
- Sits between the weight/activation fetch and the activation stage of a neuron layer.

Parameters:
- DATA_WIDTH, 8, signed activation width per lane
- WEIGHT_WIDTH, 8, signed weight width per lane
- VECTOR_WIDTH, 4, number of parallel lanes
- ACC_WIDTH, 24, signed accumulator width; must be >= DATA_WIDTH+WEIGHT_WIDTH+LEN_WIDTH
- OUTPUT_WIDTH, 16, signed result width per lane
- OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before narrowing
- LEN_WIDTH, 8, width of the len port; max dot-product length is 2^LEN_WIDTH-1

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- len  in  LEN_WIDTH  number of input beats for the job, latched with start
- bias_in  in  VECTOR_WIDTH x OUTPUT_WIDTH  signed per-lane bias, latched with start
- in_valid  in  1  val_in/weight_in beat valid
- in_ready  out  1  block accepts a beat
- val_in  in  VECTOR_WIDTH x DATA_WIDTH  signed activations
- weight_in  in  VECTOR_WIDTH x WEIGHT_WIDTH  signed weights
- out_valid  out  1  sum_out valid
- out_ready  in  1  consumer accepts result
- sum_out  out  VECTOR_WIDTH x OUTPUT_WIDTH  signed per-lane result
- sat_out  out  VECTOR_WIDTH  per-lane saturation flag, qualified by out_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset:
  - State returns to IDLE immediately on rst, including mid-job; partial results are discarded.
  - in_ready, out_valid, busy, sum_out, sat_out, accumulators, product registers, beat counter and product-valid all go to 0.
- FSM states: IDLE, ACCUM, DRAIN, OUTPUT.
- IDLE:
  - in_ready=0.
  - On start=1, latch len. Each accumulator <= sign-extended bias_in[lane] to ACC_WIDTH; counter <= 0.
  - If len==0, go to DRAIN (result = bias only). Otherwise go to ACCUM.
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready. On acceptance: prod[lane] <= val_in*weight_in (full DATA_WIDTH+WEIGHT_WIDTH signed product), prod_vld <= 1, counter++.
  - With no acceptance, prod_vld <= 0.
  - When the accepted beat is number len (counter==len-1), go to DRAIN.
  - Stalls (in_valid=0) are allowed indefinitely.
- Product stage: every cycle with prod_vld=1, acc[lane] <= acc[lane] + sign-extended prod[lane]. Accumulator wraps modulo 2^ACC_WIDTH; no overflow is possible when the ACC_WIDTH rule holds.
- DRAIN:
  - in_ready=0.
  - Lasts one cycle so the final product is added; then go to OUTPUT.
- OUTPUT:
  - out_valid=1.
  - sum_out[lane] = narrow(acc[lane] >>> OUT_SHIFT), registered on entry to OUTPUT.
  - sum_out and sat_out stay stable until out_ready=1; on that handshake go to IDLE with out_valid=0 the next cycle.
- Latency:
  - Last beat accepted in cycle N -> out_valid=1 in cycle N+3 (product N+1, accumulate N+2, output register N+3).
  - len==0: start in cycle N -> out_valid in N+3.
- start is ignored outside IDLE. A new start is accepted the cycle after the output handshake, never in the same cycle.
- Beats presented while in_ready=0 are not consumed and have no effect.

Optional Feature:
- Macro MAC_VECTOR_ACC_SAT_EN.
- Defined:
  - narrow() saturates the shifted value to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1].
  - sat_out[lane]=1 when clamping occurred.
- Undefined:
  - narrow() keeps the low OUTPUT_WIDTH bits (two's-complement wrap).
  - sat_out is tied to 0.

Test Plan:
- Reset/idle: after rst, drive in_valid=1 with no start -> in_ready=0, out_valid=0, busy=0 forever; accumulators unchanged.
- Basic dot product: defaults, len=3, bias={10,0,-5,0}, beats lane0 val/weight (2,3),(4,-1),(-1,-1) -> sum_out[0]=10+6-4+1=13; out_valid exactly 3 cycles after the 3rd accept.
- Stall and backpressure: len=4 with in_valid gaps of 0,2,5 cycles, then out_ready held low 7 cycles -> result identical to the gap-free run; sum_out stable while out_valid=1 and out_ready=0; start pulses during this are ignored.
- len=0 with bias={-32768,1,2,3} -> sum_out=bias, no in_ready assertion.
- Saturation: OUT_SHIFT=0, len=8, all lanes val=127, weight=127 (sum 129032) -> with MAC_VECTOR_ACC_SAT_EN: sum_out=32767, sat_out=4'hF; without: sum_out=129032 mod 2^16 as signed (-2040), sat_out=0.
- Mid-job reset: assert rst after 2 of 5 beats -> immediate IDLE, outputs 0; a following fresh job of len=1 (3*3, bias 0) yields 9.
